// File: rtl/shift_result_stage_if.sv
// Handshake bundle between the barrel shifter, the result stage and the EX/MEM consumer.
// slave = the result stage; master = the shifter/consumer side driving it.
interface shift_result_stage_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        in_type;
  logic [REG_AW-1:0] in_dst;
  logic              in_wen;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [REG_AW-1:0] out_dst;
  logic              out_wen;
  logic              out_zero;
  logic              out_neg;
  logic              out_flag_we;

  modport slave (
    input  in_valid, in_data, in_type, in_dst, in_wen, out_ready,
    output in_ready, out_valid, out_data, out_dst, out_wen, out_zero, out_neg, out_flag_we
  );

  modport master (
    output in_valid, in_data, in_type, in_dst, in_wen, out_ready,
    input  in_ready, out_valid, out_data, out_dst, out_wen, out_zero, out_neg, out_flag_we
  );
endinterface

// File: rtl/shift_result_stage.sv
// 2-entry skid buffer capturing barrel-shifter results plus destination metadata.
// Optional zero/neg/flag-write storage is built only when SHIFT_RESULT_FLAGS_EN is defined.
module shift_result_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  shift_result_stage_if.slave  bus,
  output logic [1:0]           occupancy,
  output logic                 illegal_seen
);

`ifdef SHIFT_RESULT_FLAGS_EN
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [REG_AW-1:0] dst;
    logic              wen;
    logic              zero;
    logic              neg;
    logic              flag_we;
  } entry_t;
`else
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [REG_AW-1:0] dst;
    logic              wen;
  } entry_t;
`endif

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  state_e     state_q, state_d;
  entry_t     head_q, head_d, tail_q, tail_d, in_entry;
  logic       in_ready_q;
  logic [1:0] occ_q;
  logic       ill_q, ill_d;
  logic       legal, push, pop;

  assign legal = (bus.in_type != 2'd3);
  assign push  = bus.in_valid & in_ready_q;
  assign pop   = (state_q != EMPTY) & bus.out_ready;

  // Illegal shift types are still captured, but must never write the register file or flags.
  always_comb begin
    in_entry      = '0;
    in_entry.data = bus.in_data;
    in_entry.dst  = bus.in_dst;
    in_entry.wen  = bus.in_wen & legal;
`ifdef SHIFT_RESULT_FLAGS_EN
    in_entry.zero    = (bus.in_data == '0);
    in_entry.neg     = bus.in_data[DATA_W-1];
    in_entry.flag_we = bus.in_wen & legal;
`endif
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    ill_d   = ill_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      ill_d = ill_q | (push & ~legal);
      case (state_q)
        EMPTY: if (push) begin
          state_d = ONE;
          head_d  = in_entry;
        end
        ONE: begin
          if (push && pop) begin
            head_d = in_entry;
          end else if (push) begin
            state_d = FULL;
            tail_d  = in_entry;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: if (pop) begin
          state_d = ONE;
          head_d  = tail_q;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b1;
      occ_q      <= 2'd0;
      ill_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= (state_d != FULL);
      occ_q      <= (state_d == EMPTY) ? 2'd0 : (state_d == ONE) ? 2'd1 : 2'd2;
      ill_q      <= ill_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_data  = head_q.data;
  assign bus.out_dst   = head_q.dst;
  assign bus.out_wen   = head_q.wen;
  assign occupancy     = occ_q;
  assign illegal_seen  = ill_q;

`ifdef SHIFT_RESULT_FLAGS_EN
  assign bus.out_zero    = head_q.zero;
  assign bus.out_neg     = head_q.neg;
  assign bus.out_flag_we = head_q.flag_we;
`else
  assign bus.out_zero    = 1'b0;
  assign bus.out_neg     = 1'b0;
  assign bus.out_flag_we = 1'b0;
`endif

endmodule

// File: tb/tb_shift_result_stage.sv
// Scoreboard bench for shift_result_stage: a queue model tracks accepted entries and a
// negedge monitor compares the head, occupancy and handshake state every cycle.
module tb_shift_result_stage;
  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  localparam int EW     = DATA_W + REG_AW + 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [1:0] occupancy;
  logic       illegal_seen;

  shift_result_stage_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

  shift_result_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .bus          (bus),
    .occupancy    (occupancy),
    .illegal_seen (illegal_seen)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] q[$];
  logic          ill_m = 1'b0;

`ifdef SHIFT_RESULT_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Expected head fields {data, dst, wen, zero, neg, flag_we}
  function automatic logic [EW-1:0] mk(input logic [DATA_W-1:0] d, input logic [1:0] t,
                                       input logic [REG_AW-1:0] dst, input logic wen);
    logic lg, z, n, f;
    lg = (t != 2'd3);
    z  = FL & (d == '0);
    n  = FL & d[DATA_W-1];
    f  = FL & wen & lg;
    return {d, dst, wen & lg, z, n, f};
  endfunction

  // Reference model: plain in-order queue of at most 2 entries
  initial forever begin
    @(posedge clk);
    if (rst) begin
      q.delete();
      ill_m = 1'b0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (bus.in_valid && q.size() < 2 && bus.in_type == 2'd3) ill_m = 1'b1;
      if (bus.in_valid && q.size() < 2) begin
        if (bus.out_ready && q.size() > 0) void'(q.pop_front());
        q.push_back(mk(bus.in_data, bus.in_type, bus.in_dst, bus.in_wen));
      end else if (bus.out_ready && q.size() > 0) begin
        void'(q.pop_front());
      end
    end
  end

  // Monitor
  initial forever begin
    @(negedge clk);
    chk("occupancy", {30'd0, occupancy}, q.size());
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, q.size() < 2});
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() != 0});
    chk("illegal_seen", {31'd0, illegal_seen}, {31'd0, ill_m});
    if (q.size() != 0)
      chk("head", {9'd0, bus.out_data, bus.out_dst, bus.out_wen, bus.out_zero, bus.out_neg,
                   bus.out_flag_we}, {9'd0, q[0]});
  end

  task automatic drive(input logic [15:0] d, input logic [1:0] t, input logic [2:0] dst,
                       input logic wen);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_type  = t;
    bus.in_dst   = dst;
    bus.in_wen   = wen;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_type = '0;
    bus.in_dst = '0;
    bus.in_wen = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_occ", {30'd0, occupancy}, 32'd0);
    chk("rst_fields", {bus.out_data, bus.out_dst, bus.out_wen, bus.out_zero, bus.out_neg,
                       bus.out_flag_we}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Scenario 1: single push, negative non-zero result
    bus.out_ready = 1'b1;
    drive(16'h8001, 2'd0, 3'd5, 1'b1);
    chk("s1_data", {16'd0, bus.out_data}, 32'h8001);
    chk("s1_dst", {29'd0, bus.out_dst}, 32'd5);
    chk("s1_neg", {31'd0, bus.out_neg}, {31'd0, FL});
    chk("s1_zero", {31'd0, bus.out_zero}, 32'd0);
    chk("s1_flag_we", {31'd0, bus.out_flag_we}, {31'd0, FL});
    idle(1);

    // Scenario 2: fill with consumer stalled, then drain
    bus.out_ready = 1'b0;
    drive(16'h0000, 2'd1, 3'd1, 1'b1);
    drive(16'h1234, 2'd2, 3'd2, 1'b1);
    chk("s2_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("s2_occ", {30'd0, occupancy}, 32'd2);
    chk("s2_head", {16'd0, bus.out_data}, 32'h0000);
    chk("s2_zero", {31'd0, bus.out_zero}, {31'd0, FL});
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("s2_pop1", {16'd0, bus.out_data}, 32'h1234);
    chk("s2_occ1", {30'd0, occupancy}, 32'd1);
    @(posedge clk); #1;
    chk("s2_occ0", {30'd0, occupancy}, 32'd0);

    // Scenario 3: back-to-back stream at full throughput
    for (int k = 0; k < 8; k++) begin
      drive(16'h0001 << k, 2'd1, 3'(k), 1'b1);
      bus.in_valid = 1'b1;
      chk("s3_stream", {16'd0, bus.out_data}, 32'h1 << k);
      chk("s3_occ", {31'd0, occupancy > 2'd1}, 32'd0);
    end
    idle(2);

    // Scenario 4: flush while full, with a same-cycle push that must be dropped
    bus.out_ready = 1'b0;
    drive(16'h00A1, 2'd0, 3'd3, 1'b1);
    drive(16'h00A2, 2'd0, 3'd4, 1'b1);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 16'hBEEF;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("s4_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("s4_occ", {30'd0, occupancy}, 32'd0);
    idle(2);

    // Scenario 5: illegal type is captured without write enables, sticky across flush
    drive(16'h00FF, 2'd3, 3'd2, 1'b1);
    chk("s5_data", {16'd0, bus.out_data}, 32'h00FF);
    chk("s5_wen", {31'd0, bus.out_wen}, 32'd0);
    chk("s5_flag_we", {31'd0, bus.out_flag_we}, 32'd0);
    chk("s5_ill", {31'd0, illegal_seen}, 32'd1);
    bus.out_ready = 1'b1;
    idle(1);
    bus.out_ready = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("s5_ill_flush", {31'd0, illegal_seen}, 32'd1);

    // Reset mid-transfer drops buffered entries and clears the sticky flag
    drive(16'h0101, 2'd1, 3'd6, 1'b1);
    drive(16'h0202, 2'd1, 3'd7, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_mid_occ", {30'd0, occupancy}, 32'd0);
    chk("rst_mid_ill", {31'd0, illegal_seen}, 32'd0);

    // An illegal push dropped by flush must not set the sticky flag
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_type = 2'd3;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_drop_ill", {31'd0, illegal_seen}, 32'd0);
    chk("flush_drop_valid", {31'd0, bus.out_valid}, 32'd0);

    bus.out_ready = 1'b1;
    drive(16'h7FFF, 2'd2, 3'd1, 1'b0);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d entries expected=0", q.size());
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
